// File: rtl/nf10_stamp_capture_pkg.sv
// Shared constants for the timestamp capture block: packet tracker encoding
// and default widths.
package nf10_stamp_capture_pkg;

    typedef enum logic {
        WAIT_SOP = 1'b0,
        IN_PKT   = 1'b1
    } pkt_state_t;

    localparam int TIMESTAMP_WIDTH_DEF = 64;
    localparam int DROP_COUNT_W        = 32;

endpackage

// File: rtl/nf10_stamp_capture_stamp_fifo.sv
// First-word-fall-through timestamp FIFO with flush, register-array storage
// and a head output forced to zero while empty.
module nf10_stamp_capture_stamp_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_BITS:0]   count
);
    import nf10_stamp_capture_pkg::*;

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_COUNT);
    assign count     = r_count;
    assign w_pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = push & (~full | w_pop_ok);
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/nf10_stamp_capture.sv
// Inline AXI-Stream tap: passes traffic through untouched and samples the
// stamp counter into a FIFO on the first accepted beat of every packet.
module nf10_stamp_capture
    import nf10_stamp_capture_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int TIMESTAMP_WIDTH    = TIMESTAMP_WIDTH_DEF,
    parameter int FIFO_DEPTH_BITS    = 4
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic [TIMESTAMP_WIDTH-1:0]      stamp_counter,
    input  logic                            capture_en,
    input  logic                            ts_flush,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    input  logic                            ts_rd_en,
    output logic [TIMESTAMP_WIDTH-1:0]      ts_dout,
    output logic                            ts_empty,
    output logic [FIFO_DEPTH_BITS:0]        ts_count,
    output logic [DROP_COUNT_W-1:0]         drop_count
);

    pkt_state_t              r_state;
    pkt_state_t              w_state_next;
    logic                    w_beat;
    logic                    w_sop;
    logic                    w_capture;
    logic                    w_pop_ok;
    logic                    w_drop;
    logic                    w_full;
    logic                    w_empty;
    logic [DROP_COUNT_W-1:0] r_drop_count;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tlast  = s_axis_tlast;
    assign s_axis_tready = m_axis_tready;

    assign w_beat    = s_axis_tvalid & m_axis_tready;
    assign w_sop     = w_beat & (r_state == WAIT_SOP);
    assign w_capture = w_sop & capture_en;
    assign w_pop_ok  = ts_rd_en & ~w_empty;
    assign w_drop    = w_capture & w_full & ~w_pop_ok;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) r_state <= WAIT_SOP;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_SOP: if (w_beat && !s_axis_tlast) w_state_next = IN_PKT;
            IN_PKT:   if (w_beat && s_axis_tlast)  w_state_next = WAIT_SOP;
            default:  w_state_next = WAIT_SOP;
        endcase
    end

    // Flush wins over a drop in the same cycle; the count saturates.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset || ts_flush)
            r_drop_count <= '0;
        else if (w_drop && (r_drop_count != '1))
            r_drop_count <= r_drop_count + 1'b1;
    end

    assign drop_count = r_drop_count;
    assign ts_empty   = w_empty;

    nf10_stamp_capture_stamp_fifo #(
        .WIDTH      (TIMESTAMP_WIDTH),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_stamp_fifo (
        .clk   (axi_aclk),
        .rst   (axi_reset),
        .push  (w_capture),
        .pop   (ts_rd_en),
        .flush (ts_flush),
        .din   (stamp_counter),
        .dout  (ts_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (ts_count)
    );

endmodule

// File: tb/tb_nf10_stamp_capture.sv
// Directed bench for nf10_stamp_capture with a queue-based reference model.
module tb_nf10_stamp_capture;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int TW = 64;
    localparam int DB = 4;
    localparam int DEPTH = 1 << DB;

    logic           axi_aclk = 1'b0;
    logic           axi_reset;
    logic [TW-1:0]  stamp_counter;
    logic           capture_en;
    logic           ts_flush;
    logic [DW-1:0]  s_axis_tdata;
    logic [DW/8-1:0] s_axis_tstrb;
    logic [UW-1:0]  s_axis_tuser;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic [DW-1:0]  m_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb;
    logic [UW-1:0]  m_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready;
    logic           ts_rd_en;
    logic [TW-1:0]  ts_dout;
    logic           ts_empty;
    logic [DB:0]    ts_count;
    logic [31:0]    drop_count;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    logic [TW-1:0] m_q[$];
    logic [31:0]   m_drop;
    bit            m_in_pkt;

    always #5 axi_aclk = ~axi_aclk;

    nf10_stamp_capture #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .TIMESTAMP_WIDTH    (TW),
        .FIFO_DEPTH_BITS    (DB)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .stamp_counter (stamp_counter),
        .capture_en    (capture_en),
        .ts_flush      (ts_flush),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .ts_rd_en      (ts_rd_en),
        .ts_dout       (ts_dout),
        .ts_empty      (ts_empty),
        .ts_count      (ts_count),
        .drop_count    (drop_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of timestamps plus a packet-open flag.
    always @(posedge axi_aclk) begin
        bit beat, sop, pop;
        if (axi_reset) begin
            m_q.delete();
            m_drop   = 0;
            m_in_pkt = 0;
        end else begin
            beat = s_axis_tvalid && m_axis_tready;
            sop  = beat && !m_in_pkt;
            if (ts_flush) begin
                m_q.delete();
                m_drop = 0;
            end else begin
                pop = ts_rd_en && (m_q.size() > 0);
                if (pop) void'(m_q.pop_front());
                if (sop && capture_en) begin
                    if (m_q.size() < DEPTH) m_q.push_back(stamp_counter);
                    else if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
                end
            end
            if (beat) m_in_pkt = !s_axis_tlast;
        end
    end

    always @(negedge axi_aclk) begin
        if (chk_on) begin
            chk("ts_count", 64'(ts_count), 64'(m_q.size()));
            chk("ts_empty", 64'(ts_empty), 64'(m_q.size() == 0));
            chk("ts_dout", ts_dout, (m_q.size() > 0) ? m_q[0] : 64'h0);
            chk("drop_count", 64'(drop_count), 64'(m_drop));
            chk("pass_tdata", 64'(m_axis_tdata !== s_axis_tdata), 64'h0);
            chk("pass_tstrb", 64'(m_axis_tstrb !== s_axis_tstrb), 64'h0);
            chk("pass_tuser", 64'(m_axis_tuser !== s_axis_tuser), 64'h0);
            chk("pass_ctl", {61'h0, m_axis_tvalid, m_axis_tlast, s_axis_tready},
                {61'h0, s_axis_tvalid, s_axis_tlast, m_axis_tready});
        end
    end

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic drive_beat(input logic last, input logic [TW-1:0] ts);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tdata  = {8{$urandom}};
        s_axis_tstrb  = {$urandom};
        s_axis_tuser  = {4{$urandom}};
        stamp_counter = ts;
    endtask

    task automatic send_pkt(input int n, input logic [TW-1:0] ts);
        for (int i = 0; i < n; i++) begin
            drive_beat(i == n - 1, ts + TW'(i));
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic flush_pulse();
        ts_flush = 1'b1;
        tick();
        ts_flush = 1'b0;
    endtask

    initial begin
        axi_reset = 1'b1; capture_en = 1'b1; ts_flush = 1'b0; ts_rd_en = 1'b0;
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0; stamp_counter = '0;
        tick();
        chk_on = 1;
        tick();
        chk("rst_empty", 64'(ts_empty), 64'h1);
        chk("rst_count", 64'(ts_count), 64'h0);
        chk("rst_dout", ts_dout, 64'h0);
        chk("rst_drop", 64'(drop_count), 64'h0);
        axi_reset = 1'b0;
        tick();

        // Three 4-beat packets, then drain.
        send_pkt(4, 64'h100);
        send_pkt(4, 64'h200);
        send_pkt(4, 64'h300);
        tick();
        chk("p3_count", 64'(ts_count), 64'd3);
        chk("p3_head", ts_dout, 64'h100);
        ts_rd_en = 1'b1;
        tick();
        chk("pop1", ts_dout, 64'h200);
        tick();
        chk("pop2", ts_dout, 64'h300);
        tick();
        ts_rd_en = 1'b0;
        chk("drain_empty", 64'(ts_empty), 64'h1);
        chk("drain_dout", ts_dout, 64'h0);

        // Back-to-back single-beat packets.
        send_pkt(1, 64'd5);
        send_pkt(1, 64'd6);
        send_pkt(1, 64'd7);
        chk("sb_count", 64'(ts_count), 64'd3);
        chk("sb_head", ts_dout, 64'd5);
        flush_pulse();
        chk("flush_count", 64'(ts_count), 64'd0);

        // SOP held off by downstream backpressure for ten cycles.
        m_axis_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive_beat(1'b0, 64'h10 + 64'(k));
            tick();
        end
        chk("stall_none", 64'(ts_count), 64'd0);
        m_axis_tready = 1'b1;
        stamp_counter = 64'h1A;
        tick();
        send_pkt(3, 64'h1B);
        chk("stall_count", 64'(ts_count), 64'd1);
        chk("stall_val", ts_dout, 64'h1A);
        flush_pulse();

        // Overflow: 20 packets into 16 slots.
        for (int p = 0; p < 20; p++) send_pkt(2, 64'h1000 + 64'(p * 16));
        chk("ovf_count", 64'(ts_count), 64'd16);
        chk("ovf_drop", 64'(drop_count), 64'd4);
        chk("ovf_head", ts_dout, 64'h1000);
        ts_rd_en = 1'b1;
        send_pkt(1, 64'hABC);
        ts_rd_en = 1'b0;
        chk("pp_count", 64'(ts_count), 64'd16);
        chk("pp_drop", 64'(drop_count), 64'd4);
        chk("pp_head", ts_dout, 64'h1010);

        // Flush beats a simultaneous SOP and pop on a full FIFO.
        ts_flush = 1'b1; ts_rd_en = 1'b1;
        send_pkt(1, 64'hDEAD);
        ts_flush = 1'b0; ts_rd_en = 1'b0;
        chk("fl_count", 64'(ts_count), 64'd0);
        chk("fl_drop", 64'(drop_count), 64'd0);
        chk("fl_empty", 64'(ts_empty), 64'h1);

        // Capture disabled for two packets.
        capture_en = 1'b0;
        send_pkt(3, 64'h40);
        send_pkt(2, 64'h50);
        capture_en = 1'b1;
        send_pkt(2, 64'h77);
        chk("cen_count", 64'(ts_count), 64'd1);
        chk("cen_val", ts_dout, 64'h77);
        chk("cen_drop", 64'(drop_count), 64'd0);

        // Reset in the middle of a packet.
        drive_beat(1'b0, 64'h60); tick();
        drive_beat(1'b0, 64'h61); tick();
        s_axis_tvalid = 1'b0;
        axi_reset = 1'b1;
        tick();
        axi_reset = 1'b0;
        chk("mr_count", 64'(ts_count), 64'd0);
        send_pkt(1, 64'h55);
        chk("mr_sop_count", 64'(ts_count), 64'd1);
        chk("mr_sop_val", ts_dout, 64'h55);
        tick();

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
